// File: rtl/seg_pkg.sv
// Shared types, defaults and helpers for the multi-channel 7-segment scan controller.
// The segment-off pattern is exported here so the downstream decoder uses the same value.
package seg_pkg;

    localparam int NUM_CH_DEF       = 2;
    localparam int DIGITS_DEF       = 4;
    localparam int CLK_DIV_DEF      = 50000;
    localparam int BLINK_FRAMES_DEF = 64;

    localparam int MAX_DIGITS = 32;

    localparam logic [6:0] SEG_OFF = 7'b000_0000;

    typedef enum logic {
        PHASE_VISIBLE = 1'b0,
        PHASE_BLANK   = 1'b1
    } blink_phase_e;

    function automatic int cnt_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

    function automatic int nibble_idx(input int c, input int d, input int digits);
        return (c * digits + d) * 4;
    endfunction

    // Shift-based so that no wide variable index ever lands on a bit-select.
    function automatic logic [MAX_DIGITS-1:0] onehot(input int idx, input int digits);
        logic [MAX_DIGITS-1:0] r;
        r = '0;
        if (idx >= 0 && idx < digits && idx < MAX_DIGITS)
            r = {{(MAX_DIGITS-1){1'b0}}, 1'b1} << idx;
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_scan_timer.sv
// Digit-slot prescaler and digit index for the scan controller.
// frame is registered, so it lines up with the edge that moves the display to digit 0.
module scan_timer
    import seg_pkg::*;
#(
    parameter int DIGITS  = DIGITS_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         tick,
    output logic                         wrap,
    output logic                         frame,
    output logic [cnt_width(DIGITS)-1:0] idx
);

    localparam int PW = cnt_width(CLK_DIV);
    localparam int IW = cnt_width(DIGITS);

    logic [PW-1:0] pre;
    logic [IW-1:0] idx_nxt;

    assign tick = (pre == PW'(CLK_DIV - 1));
    assign wrap = tick && (idx == IW'(DIGITS - 1));

    always_comb begin
        idx_nxt = idx;
        if (tick)
            idx_nxt = wrap ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre   <= '0;
            idx   <= '0;
            frame <= 1'b0;
        end else begin
            pre   <= tick ? '0 : pre + 1'b1;
            idx   <= idx_nxt;
            frame <= wrap;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multi-channel 7-segment scan controller: double-buffered display data swapped at frame
// boundaries, per-channel leading-zero blanking and a globally phased blink.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_CH       = NUM_CH_DEF,
    parameter int DIGITS       = DIGITS_DEF,
    parameter int CLK_DIV      = CLK_DIV_DEF,
    parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [NUM_CH*DIGITS*4-1:0] load_data,
    output logic                       load_ready,
    input  logic [NUM_CH-1:0]          blank_lz,
    input  logic [NUM_CH-1:0]          blink_en,
    output logic [NUM_CH*4-1:0]        LEDx,
    output logic [NUM_CH-1:0]          blank,
    output logic [DIGITS-1:0]          ct,
    output logic                       frame
);

    localparam int DW = NUM_CH * DIGITS * 4;
    localparam int IW = cnt_width(DIGITS);
    localparam int BW = cnt_width(BLINK_FRAMES);

    logic          tick;
    logic          wrap;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nxt;

    logic [DW-1:0] active;
    logic [DW-1:0] shadow;
    logic [DW-1:0] active_nxt;
    logic          pending;

    logic [BW-1:0] bcnt;
    logic [BW-1:0] bcnt_nxt;
    blink_phase_e  phase;
    blink_phase_e  phase_nxt;

    logic [3:0]        nib_nxt [NUM_CH][DIGITS];
    logic [DIGITS-1:0] lz_mask [NUM_CH];

    logic [NUM_CH*4-1:0] led_d;
    logic [NUM_CH-1:0]   blank_d;
    logic [DIGITS-1:0]   ct_d;

    scan_timer #(
        .DIGITS  (DIGITS),
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .wrap  (wrap),
        .frame (frame),
        .idx   (idx)
    );

    always_comb begin
        idx_nxt = idx;
        if (tick)
            idx_nxt = wrap ? '0 : idx + 1'b1;
    end

    // Outputs are built from the post-swap buffer so new data appears exactly on digit 0.
    assign active_nxt = (wrap && pending) ? shadow : active;
    assign load_ready = ~pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else if (wrap && pending) begin
            active  <= shadow;
            pending <= 1'b0;
        end else if (load && !pending) begin
            shadow  <= load_data;
            pending <= 1'b1;
        end
    end

    always_comb begin
        bcnt_nxt  = bcnt;
        phase_nxt = phase;
        if (wrap) begin
            if (bcnt == BW'(BLINK_FRAMES - 1)) begin
                bcnt_nxt  = '0;
                phase_nxt = (phase == PHASE_VISIBLE) ? PHASE_BLANK : PHASE_VISIBLE;
            end else begin
                bcnt_nxt = bcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt  <= '0;
            phase <= PHASE_VISIBLE;
        end else begin
            bcnt  <= bcnt_nxt;
            phase <= phase_nxt;
        end
    end

    // A digit above 0 is a leading zero when it and every digit above it are zero.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        for (genvar d = 0; d < DIGITS; d++) begin : g_dig
            assign nib_nxt[c][d] = active_nxt[nibble_idx(c, d, DIGITS) +: 4];
            if (d == 0) begin : g_lsd
                assign lz_mask[c][d] = 1'b0;
            end else begin : g_upper
                assign lz_mask[c][d] =
                    (active_nxt[nibble_idx(c, DIGITS, DIGITS)-1 : nibble_idx(c, d, DIGITS)] == '0);
            end
        end

        assign led_d[c*4 +: 4] = nib_nxt[c][idx_nxt];
        assign blank_d[c]      = (blank_lz[c] & lz_mask[c][idx_nxt])
                               | (blink_en[c] & (phase_nxt == PHASE_BLANK));
    end

    assign ct_d = DIGITS'(onehot(int'(idx_nxt), DIGITS));

    always_ff @(posedge clk) begin
        if (reset) begin
            ct    <= {{(DIGITS-1){1'b0}}, 1'b1};
            LEDx  <= '0;
            blank <= '1;
        end else begin
            ct    <= ct_d;
            LEDx  <= led_d;
            blank <= blank_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl; per-digit expectations are queued
// when data is loaded and popped as each digit slot of the following frame is scanned.
module tb_seg_scan_ctrl;

    localparam int NUM_CH       = 2;
    localparam int DIGITS       = 4;
    localparam int CLK_DIV      = 4;
    localparam int BLINK_FRAMES = 2;

    logic                       clk;
    logic                       reset;
    logic                       load;
    logic [NUM_CH*DIGITS*4-1:0] load_data;
    logic                       load_ready;
    logic [NUM_CH-1:0]          blank_lz;
    logic [NUM_CH-1:0]          blink_en;
    logic [NUM_CH*4-1:0]        LEDx;
    logic [NUM_CH-1:0]          blank;
    logic [DIGITS-1:0]          ct;
    logic                       frame;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] ct;
        logic [7:0] led;
        logic [1:0] blank;
    } exp_t;

    exp_t sb[$];

    seg_scan_ctrl #(
        .NUM_CH       (NUM_CH),
        .DIGITS       (DIGITS),
        .CLK_DIV      (CLK_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_data  (load_data),
        .load_ready (load_ready),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .LEDx       (LEDx),
        .blank      (blank),
        .ct         (ct),
        .frame      (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] data);
        load_data = data;
        load      = 1'b1;
        step(1);
        load      = 1'b0;
    endtask

    task automatic doReset(input int n);
        reset = 1'b1;
        step(n);
        reset = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ct"},    32'(ct),         32'h1);
        checkOutput({tag, "_blank"}, 32'(blank),      32'h3);
        checkOutput({tag, "_led"},   32'(LEDx),       32'h0);
        checkOutput({tag, "_ready"}, 32'(load_ready), 32'h1);
        checkOutput({tag, "_frame"}, 32'(frame),      32'h0);
    endtask

    task automatic pushFrame(input logic [31:0] leds, input logic [7:0] blanks);
        exp_t e;
        for (int d = 0; d < DIGITS; d++) begin
            e.ct    = 4'b0001 << d;
            e.led   = 8'(leds >> (d * 8));
            e.blank = 2'(blanks >> (d * 2));
            sb.push_back(e);
        end
    endtask

    task automatic waitFrame(input bit hold_low);
        int n;
        n = 0;
        while (frame !== 1'b1 && n < 40) begin
            if (hold_low)
                checkOutput("ready_held_low", 32'(load_ready), 32'h0);
            step(1);
            n++;
        end
        checkOutput("frame_pulse", 32'(frame), 32'h1);
    endtask

    task automatic checkFrame(input logic exp_ready, input bit hold_low);
        exp_t e;
        waitFrame(hold_low);
        checkOutput("frame_ready", 32'(load_ready), 32'(exp_ready));
        for (int d = 0; d < DIGITS; d++) begin
            step(d == 0 ? 1 : CLK_DIV);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $error("[TB] FAIL scoreboard_empty: observed=0 entries expected>0");
            end else begin
                e = sb.pop_front();
                checkOutput($sformatf("ct_d%0d", d),    32'(ct),    32'(e.ct));
                checkOutput($sformatf("led_d%0d", d),   32'(LEDx),  32'(e.led));
                checkOutput($sformatf("blank_d%0d", d), 32'(blank), 32'(e.blank));
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        load      = 1'b0;
        load_data = '0;
        blank_lz  = '0;
        blink_en  = '0;

        $display("[TB] reset and scan timing");
        doReset(3);
        checkResetState("rst");
        step(3);
        checkOutput("ct_before_tick", 32'(ct), 32'h1);
        step(1);
        checkOutput("ct_after_tick", 32'(ct), 32'h2);
        step(11);
        checkOutput("frame_before", 32'(frame), 32'h0);
        step(1);
        checkOutput("frame_first", 32'(frame), 32'h1);
        checkOutput("frame_ct", 32'(ct), 32'h1);
        step(1);
        checkOutput("frame_one_cycle", 32'(frame), 32'h0);

        $display("[TB] mid-frame load");
        applyStimulus({16'h0567, 16'h1234});
        checkOutput("ready_drop", 32'(load_ready), 32'h0);
        checkOutput("led_before_swap", 32'(LEDx), 32'h0);
        pushFrame(32'h01526374, 8'b00_00_00_00);
        checkFrame(1'b1, 1'b0);

        $display("[TB] leading-zero blanking");
        blank_lz = 2'b10;
        applyStimulus({16'h0007, 16'h1234});
        pushFrame(32'h01020374, 8'b10_10_10_00);
        checkFrame(1'b1, 1'b0);
        step(2);
        applyStimulus({16'h0000, 16'h1234});
        checkOutput("wrap_load_frame", 32'(frame), 32'h1);
        checkOutput("wrap_load_pending", 32'(load_ready), 32'h0);
        pushFrame(32'h01020374, 8'b10_10_10_00);
        checkFrame(1'b0, 1'b0);
        pushFrame(32'h01020304, 8'b10_10_10_00);
        checkFrame(1'b1, 1'b0);

        $display("[TB] load while busy");
        step(5);
        applyStimulus({16'h0890, 16'h5678});
        checkOutput("busy_ready_a", 32'(load_ready), 32'h0);
        applyStimulus(32'hFFFF_FFFF);
        checkOutput("busy_ready_b", 32'(load_ready), 32'h0);
        pushFrame(32'h05869708, 8'b10_00_00_00);
        checkFrame(1'b1, 1'b1);

        $display("[TB] blink");
        blank_lz = 2'b00;
        blink_en = 2'b01;
        doReset(1);
        applyStimulus({16'h4321, 16'h8765});
        pushFrame(32'h48372615, 8'b00_00_00_00);
        checkFrame(1'b1, 1'b0);
        pushFrame(32'h48372615, 8'b01_01_01_01);
        checkFrame(1'b1, 1'b0);
        pushFrame(32'h48372615, 8'b01_01_01_01);
        checkFrame(1'b1, 1'b0);
        pushFrame(32'h48372615, 8'b00_00_00_00);
        checkFrame(1'b1, 1'b0);
        pushFrame(32'h48372615, 8'b00_00_00_00);
        checkFrame(1'b1, 1'b0);
        pushFrame(32'h48372615, 8'b01_01_01_01);
        checkFrame(1'b1, 1'b0);

        $display("[TB] reset with pending data");
        blink_en = 2'b00;
        applyStimulus(32'h9999_9999);
        checkOutput("pending_before_reset", 32'(load_ready), 32'h0);
        doReset(1);
        checkResetState("mid_rst");
        pushFrame(32'h00000000, 8'b00_00_00_00);
        checkFrame(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
